// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for the modulo-N up/down counter.
// The master drives controls; the counter (slave) returns count and flags.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             dir;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             terminal;

    modport master (
        output clear, load, load_value, enable, dir, step,
        input  count, overflow, underflow, terminal
    );

    modport slave (
        input  clear, load, load_value, enable, dir, step,
        output count, overflow, underflow, terminal
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with programmable step, wrap or saturate,
// synchronous clear/load and one-cycle overflow/underflow pulses.
module updown_mod_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255,
    parameter int SATURATE  = 0
) (
    input  logic clk,
    input  logic reset_n,
    updown_mod_counter_if.slave bus
);
    generate
        if (MAX_COUNT < 1 ||
            longint'(MAX_COUNT) >= (longint'(1) << WIDTH)) begin : g_bad_max
            $error("updown_mod_counter: MAX_COUNT out of range");
        end
    endgenerate

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] MODV = (WIDTH+1)'(longint'(MAX_COUNT) + 1);

    logic [WIDTH-1:0] cnt;
    logic             ovf;
    logic             udf;

    logic [WIDTH:0] s;
    logic [WIDTH:0] c;
    logic [WIDTH:0] lv;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] nxt;
    logic           nxt_ovf;
    logic           nxt_udf;

    // One extra bit keeps count+step and the wrap terms from truncating.
    always_comb begin
        s       = ({1'b0, bus.step} > MAXV) ? MAXV : {1'b0, bus.step};
        c       = {1'b0, cnt};
        lv      = {1'b0, bus.load_value};
        sum     = c + s;
        nxt     = c;
        nxt_ovf = 1'b0;
        nxt_udf = 1'b0;
        if (bus.clear) begin
            nxt = '0;
        end else if (bus.load) begin
            nxt = (lv > MAXV) ? MAXV : lv;
        end else if (bus.enable && s != '0) begin
            if (bus.dir) begin
                if (sum > MAXV) begin
                    nxt_ovf = 1'b1;
                    nxt     = (SATURATE != 0) ? MAXV : sum - MODV;
                end else begin
                    nxt = sum;
                end
            end else begin
                if (s > c) begin
                    nxt_udf = 1'b1;
                    nxt     = (SATURATE != 0) ? '0 : c + (MODV - s);
                end else begin
                    nxt = c - s;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            cnt <= nxt[WIDTH-1:0];
            ovf <= nxt_ovf;
            udf <= nxt_udf;
        end
    end

    assign bus.count     = cnt;
    assign bus.overflow  = ovf;
    assign bus.underflow = udf;
    assign bus.terminal  = bus.dir ? ({1'b0, cnt} == MAXV) : (cnt == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three configurations share one stimulus
// stream and are compared against an integer model every cycle.
module tb_updown_mod_counter;
    logic clk;
    logic reset_n;

    logic       clr;
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       dr;
    logic [7:0] st;

    int total = 0;
    int bad   = 0;

    updown_mod_counter_if #(.WIDTH(8)) ia ();
    updown_mod_counter_if #(.WIDTH(8)) ib ();
    updown_mod_counter_if #(.WIDTH(8)) ic ();

    assign ia.clear = clr;  assign ia.load = ld;  assign ia.load_value = lv;
    assign ia.enable = en;  assign ia.dir = dr;   assign ia.step = st;
    assign ib.clear = clr;  assign ib.load = ld;  assign ib.load_value = lv;
    assign ib.enable = en;  assign ib.dir = dr;   assign ib.step = st;
    assign ic.clear = clr;  assign ic.load = ld;  assign ic.load_value = lv;
    assign ic.enable = en;  assign ic.dir = dr;   assign ic.step = st;

    updown_mod_counter #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(ia)
    );
    updown_mod_counter #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(0)) u_b (
        .clk(clk), .reset_n(reset_n), .bus(ib)
    );
    updown_mod_counter #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1)) u_c (
        .clk(clk), .reset_n(reset_n), .bus(ic)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int mx[3]  = '{255, 9, 9};
    bit sat[3] = '{1'b0, 1'b0, 1'b1};
    int m[3];
    bit mo[3];
    bit mu[3];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m[k] = 0; mo[k] = 1'b0; mu[k] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 3; k++) begin
            int s;
            mo[k] = 1'b0;
            mu[k] = 1'b0;
            s = (int'(st) > mx[k]) ? mx[k] : int'(st);
            if (clr) begin
                m[k] = 0;
            end else if (ld) begin
                m[k] = (int'(lv) > mx[k]) ? mx[k] : int'(lv);
            end else if (en && s != 0) begin
                if (dr) begin
                    if (m[k] + s <= mx[k]) m[k] = m[k] + s;
                    else begin
                        mo[k] = 1'b1;
                        m[k]  = sat[k] ? mx[k] : m[k] + s - (mx[k] + 1);
                    end
                end else begin
                    if (s <= m[k]) m[k] = m[k] - s;
                    else begin
                        mu[k] = 1'b1;
                        m[k]  = sat[k] ? 0 : m[k] + (mx[k] + 1) - s;
                    end
                end
            end
        end
    endfunction

    task automatic check_all(input string tag);
        int gc, go, gu, gt;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin gc = ia.count; go = ia.overflow; gu = ia.underflow; gt = ia.terminal; end
                1: begin gc = ib.count; go = ib.overflow; gu = ib.underflow; gt = ib.terminal; end
                default: begin gc = ic.count; go = ic.overflow; gu = ic.underflow; gt = ic.terminal; end
            endcase
            chk($sformatf("%s.count[%0d]", tag, k), gc, m[k]);
            chk($sformatf("%s.ovf[%0d]", tag, k), go, int'(mo[k]));
            chk($sformatf("%s.udf[%0d]", tag, k), gu, int'(mu[k]));
            chk($sformatf("%s.term[%0d]", tag, k), gt,
                dr ? int'(m[k] == mx[k]) : int'(m[k] == 0));
            chk($sformatf("%s.excl[%0d]", tag, k), go & gu, 0);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit c, input bit l, input int v,
                         input bit e, input bit d, input int s);
        clr = c; ld = l; lv = 8'(v); en = e; dr = d; st = 8'(s);
    endtask

    int bseq[4] = '{3, 6, 9, 2};
    int cseq[4] = '{5, 1, 0, 0};

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #22;
        check_all("reset");
        chk("reset.a", int'(ia.count), 0);
        reset_n = 1'b1;

        drive(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) tick("up1");
        chk("basic5", int'(ia.count), 5);

        drive(0, 1, 8'hFE, 1, 1, 1);
        tick("ldFE");
        drive(0, 0, 0, 1, 1, 1);
        tick("toFF");
        chk("a_ff", int'(ia.count), 255);
        chk("a_ff_ovf", int'(ia.overflow), 0);
        tick("to00");
        chk("a_00", int'(ia.count), 0);
        chk("a_00_ovf", int'(ia.overflow), 1);

        drive(1, 0, 0, 0, 1, 0);
        tick("clr");
        drive(0, 0, 0, 1, 1, 3);
        for (int i = 0; i < 4; i++) begin
            tick("mod10");
            chk("b_seq", int'(ib.count), bseq[i]);
            chk("b_seq_ovf", int'(ib.overflow), int'(i == 3));
        end
        drive(0, 0, 0, 1, 0, 3);
        tick("mod10dn");
        chk("b_dn", int'(ib.count), 9);
        chk("b_dn_udf", int'(ib.underflow), 1);

        drive(0, 1, 8, 0, 1, 3);
        tick("ld8");
        drive(0, 0, 0, 1, 1, 3);
        tick("sat1");
        chk("c_sat1", int'(ic.count), 9);
        chk("c_sat1_ovf", int'(ic.overflow), 1);
        tick("sat2");
        chk("c_sat2", int'(ic.count), 9);
        chk("c_sat2_ovf", int'(ic.overflow), 1);
        drive(0, 0, 0, 1, 0, 4);
        for (int i = 0; i < 4; i++) begin
            tick("satdn");
            chk("c_dn", int'(ic.count), cseq[i]);
            chk("c_dn_udf", int'(ic.underflow), int'(i >= 2));
        end

        drive(1, 1, 8'hA5, 1, 1, 1);
        tick("clrld");
        chk("clrld_a", int'(ia.count), 0);
        drive(0, 1, 8'hF0, 0, 1, 1);
        tick("clamp");
        chk("clamp_b", int'(ib.count), 9);
        drive(0, 1, 4, 1, 1, 2);
        tick("ld_en");
        chk("ld_en_b", int'(ib.count), 4);
        drive(0, 0, 0, 1, 1, 0);
        tick("step0");
        chk("step0_b", int'(ib.count), 4);

        drive(0, 0, 0, 0, 0, 5);
        for (int i = 0; i < 4; i++) tick("hold");
        chk("hold_b", int'(ib.count), 4);

        drive(1, 0, 0, 0, 0, 0);
        tick("clr2");
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("term_dn", int'(ia.terminal), 1);
        dr = 1'b1;
        #1;
        chk("term_up", int'(ia.terminal), 0);

        drive(0, 1, 8'hFF, 0, 1, 1);
        tick("ldFF");
        drive(0, 0, 0, 1, 1, 1);
        tick("preovf");
        chk("pre_ovf", int'(ia.overflow), 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async");
        chk("async_ovf", int'(ia.overflow), 0);
        #2;
        reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 15) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            lv  = 8'($urandom_range(0, 255));
            en  = ($urandom_range(0, 3) != 0);
            dr  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 12));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised successor to the basic 8-bit counter: a modulo-N up/down counter with a programmable step, selectable wrap or saturate behaviour, a synchronous clear, and separate overflow and underflow pulses. It sits in the same example/test suite as the basic counter and is the reference DUT for multi-mode counter translation and simulation. All state is held in a single WIDTH-bit count register plus two flag registers.

## Interface

- WIDTH, 8, counter width in bits.
- MAX_COUNT, 255, terminal value; legal range 1..2^WIDTH-1; the count cycles over 0..MAX_COUNT.
- SATURATE, 0, 0 = wrap modulo MAX_COUNT+1; 1 = clamp at 0 / MAX_COUNT.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of count to 0.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value to load.
- enable  input  1  count enable.
- dir  input  1  1 = count up, 0 = count down.
- step  input  WIDTH  increment/decrement amount per enabled cycle.
- count  output  WIDTH  current count (registered).
- overflow  output  1  registered one-cycle pulse when an up-count passes MAX_COUNT.
- underflow  output  1  registered one-cycle pulse when a down-count passes 0.
- terminal  output  1  combinational: (dir==1 && count==MAX_COUNT) || (dir==0 && count==0).

## Operation

- **Reset:** reset_n low asynchronously forces count=0, overflow=0, underflow=0. terminal then reflects dir (1 when dir=0).
- **Priority per edge:** clear > load > enable > hold.
- **clear:** count←0, overflow←0, underflow←0.
- **load:** count←min(load_value, MAX_COUNT), flags←0.
- **enable with step=0:** count holds and flags←0.
- **Hold** (no clear, load or enable): count holds and flags←0. Flags are never sticky.
- **Effective step:** s = min(step, MAX_COUNT). Arithmetic is done in WIDTH+1 bits, so no intermediate truncation.
- **Up (dir=1), count+s ≤ MAX_COUNT:** count←count+s.
- **Up, count+s > MAX_COUNT, wrap mode:** count←count+s−(MAX_COUNT+1), overflow←1.
- **Up, count+s > MAX_COUNT, saturate mode:** count←MAX_COUNT, overflow←1.
- **Down (dir=0), s ≤ count:** count←count−s.
- **Down, s > count, wrap mode:** count←count+(MAX_COUNT+1)−s, underflow←1.
- **Down, s > count, saturate mode:** count←0, underflow←1.
- **Saturate at a limit:** an enabled step≠0 request at the limit keeps pulsing the flag every cycle while the request persists.
- **Exclusivity:** overflow and underflow are never both 1.
- **Parameter check:** elaboration must fail if MAX_COUNT is 0 or MAX_COUNT ≥ 2^WIDTH.

## Timing

- **Latency:** count and flags update one clk edge after the qualifying inputs are sampled; the flag pulse is coincident with the wrapped/saturated count value.
- **terminal:** zero-latency combinational function of count and dir; no state of its own.
- **Input changes:** dir, step and enable may change every cycle; each edge uses only the values sampled at that edge.
- **Simultaneous clear+load+enable:** clear wins; no flag is raised.
- **Simultaneous load+enable:** the loaded value is taken; the count does not also step that cycle.
- **Reset mid-operation:** asserting reset_n low during a flag pulse drops the flag immediately, without waiting for clk. Deassertion is synchronised externally; the first active edge after release behaves as a normal edge.
- **Throughput:** one update per clock; no stalls.

## Test plan

- Reset/basic up (WIDTH=8, MAX_COUNT=255, wrap, step=1):
  - reset_n low 20 ns -> count=00, flags 0.
  - Release, enable, dir=1, 5 edges -> count=05.
  - Load FE, 2 enabled edges -> count FF then 00, overflow=1 only on the 00 cycle.
- Modulo-10 wrap (MAX_COUNT=9, step=3, up), start at 0 -> count sequence 3, 6, 9, 2; overflow pulses only with the 2. Then dir=0 from 2, step=3 -> 9 with underflow=1.
- Saturate (MAX_COUNT=9, SATURATE=1): load 8, step=3 up -> count=9, overflow=1; a further enabled edge -> count stays 9, overflow=1 again. dir=0, step=4 from 9 -> 5, 1, 0 (underflow only on the 0 edge), then 0 with underflow=1.
- Priority/clamp:
  - clear, load (A5) and enable together -> count=00, no flags.
  - load=1 with load_value=F0 (MAX_COUNT=9) -> count=09.
  - load with enable -> loaded value only.
  - step=0 with enable -> count unchanged.
- Disable/terminal: enable=0 for 4 edges -> count unchanged, flags 0. Toggling dir at count=0 -> terminal follows combinationally (1 for dir=0, 0 for dir=1).
- Async reset mid-count: assert reset_n between edges while overflow=1 -> count=00 and overflow=0 before the next clk rising edge.
